peripheral_ram_arbiter_wb: RTL

- Wishbone B3 slave front-end plus two-requester arbiter for the team's single-port generic RAM.
- Two masters share one RAM instance.
- The RAM's write-enable, data, address and data-out are driven directly; the RAM has 1-cycle registered read latency and byte write enables.
- Classic cycles take 2 clocks per transfer. Incrementing bursts (linear/wrap4/8/16) sustain one ack per clock.

---
 rtl/peripheral_ram_arbiter_wb.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/peripheral_ram_arbiter_wb.sv
`timescale 1ns/1ps
// peripheral_ram_arbiter_wb
// Wishbone B3 slave front-end that lets two masters share one single-port RAM
// with a 1-cycle registered read and byte write enables.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   mN_adr/dat_i/sel/we    master N request (byte address, word = adr[AW+1:2])
//   mN_cyc/stb/cti/bte     master N cycle, strobe and burst qualifiers
//   mN_dat_o/ack/err       master N response (zero unless master N owns the bus)
//   ram_we/din/waddr       RAM write port (combinational in the accept clock)
//   ram_raddr/ram_dout     RAM read port (data returns one clock after address)
//
// Classic beats take two clocks (accept, then ack). Incrementing and
// constant-address bursts sustain one ack per clock: while an ack is on the
// bus for a burst beat, the read address is advanced to the following word so
// the RAM's registered output lines up with the next ack.
module peripheral_ram_arbiter_wb #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   m0_adr,
    input  logic [DW-1:0] m0_dat_i,
    input  logic [3:0]    m0_sel,
    input  logic          m0_we,
    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic [2:0]    m0_cti,
    input  logic [1:0]    m0_bte,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack,
    output logic          m0_err,
    input  logic [31:0]   m1_adr,
    input  logic [DW-1:0] m1_dat_i,
    input  logic [3:0]    m1_sel,
    input  logic          m1_we,
    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic [2:0]    m1_cti,
    input  logic [1:0]    m1_bte,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [3:0]    ram_we,
    output logic [DW-1:0] ram_din,
    output logic [AW-1:0] ram_waddr,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t state;
    logic   rr_m1;      // round-robin pointer: 1 = m1 wins the next tie
    logic   ack_r;
    logic   err_r;
    logic   burst_r;    // the ack on the bus belongs to a cti 001/010 beat

    // Owner's request, all zero while no master holds the grant so the RAM
    // port and responses are quiet in IDLE and during reset.
    logic [31:0]   o_adr;
    logic [DW-1:0] o_dat;
    logic [3:0]    o_sel;
    logic          o_we;
    logic          o_cyc;
    logic          o_stb;
    logic [2:0]    o_cti;
    logic [1:0]    o_bte;

    // NOTE: every output of an always_comb gets a default first, otherwise a
    // path that skips the assignment infers a latch.
    always_comb begin
        o_adr = '0;
        o_dat = '0;
        o_sel = '0;
        o_we  = 1'b0;
        o_cyc = 1'b0;
        o_stb = 1'b0;
        o_cti = '0;
        o_bte = '0;
        case (state)
            OWN0: begin
                o_adr = m0_adr;   o_dat = m0_dat_i; o_sel = m0_sel; o_we  = m0_we;
                o_cyc = m0_cyc;   o_stb = m0_stb;   o_cti = m0_cti; o_bte = m0_bte;
            end
            OWN1: begin
                o_adr = m1_adr;   o_dat = m1_dat_i; o_sel = m1_sel; o_we  = m1_we;
                o_cyc = m1_cyc;   o_stb = m1_stb;   o_cti = m1_cti; o_bte = m1_bte;
            end
            default: ;
        endcase
    end

    // Byte-offset and above-depth address bits carry no meaning here.
    logic unused_adr_bits;
    assign unused_adr_bits = ^{o_adr[31:AW+2], o_adr[1:0]};

    logic [AW-1:0] word;
    assign word = o_adr[AW+1:2];

    logic is_burst;     // cti 001 (constant) or 010 (incrementing)
    logic is_rsvd;      // cti 011..110
    assign is_burst = (o_cti == 3'b001) || (o_cti == 3'b010);
    assign is_rsvd  = (o_cti >= 3'b011) && (o_cti <= 3'b110);

    // Word the master will present after the current burst beat completes.
    logic [AW-1:0] next_word;
    always_comb begin
        next_word = word;
        if (o_cti == 3'b010) begin
            case (o_bte)
                2'b00:   next_word = (word == AW'(DEPTH - 1)) ? '0 : word + 1'b1;
                2'b01:   next_word = {word[AW-1:2], word[1:0] + 2'd1};
                2'b10:   next_word = {word[AW-1:3], word[2:0] + 3'd1};
                default: next_word = {word[AW-1:4], word[3:0] + 4'd1};
            endcase
        end
    end

    // A beat is taken when nothing is on the bus yet (fresh), or while a burst
    // ack is on the bus: that ack completes the presented beat, so its write
    // lands now and the next ack is issued only if this beat is not the last.
    logic fresh;
    logic cont;
    logic accept;
    logic ack_d;
    logic err_d;
    assign fresh  = ~(ack_r | err_r);
    assign cont   = ack_r & burst_r;
    assign accept = o_cyc & o_stb & (fresh | cont);
    assign ack_d  = accept & ~is_rsvd & (fresh | is_burst);
    assign err_d  = accept & is_rsvd & fresh;

    assign ram_we    = (accept & o_we & ~is_rsvd) ? o_sel : 4'b0000;
    assign ram_waddr = word;
    assign ram_din   = o_dat;
    assign ram_raddr = (ack_r & is_burst) ? next_word : word;

    assign m0_ack   = ack_r & (state == OWN0);
    assign m0_err   = err_r & (state == OWN0);
    assign m1_ack   = ack_r & (state == OWN1);
    assign m1_err   = err_r & (state == OWN1);
    assign m0_dat_o = (state == OWN0) ? ram_dout : '0;
    assign m1_dat_o = (state == OWN1) ? ram_dout : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rr_m1   <= 1'b0;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            burst_r <= 1'b0;
        end else begin
            ack_r   <= ack_d;
            err_r   <= err_d;
            burst_r <= ack_d & is_burst;
            case (state)
                IDLE: begin
                    if (m0_cyc && m1_cyc) begin
                        state <= rr_m1 ? OWN1 : OWN0;
                        rr_m1 <= ~rr_m1;
                    end else if (m0_cyc) begin
                        state <= OWN0;
                    end else if (m1_cyc) begin
                        state <= OWN1;
                    end
                end
                OWN0:    if (!m0_cyc) state <= IDLE;
                OWN1:    if (!m1_cyc) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
